// File: rtl/hazard_ctrl_nport_if.sv
// Hazard bus between pipeline and hazard controller: E/M/W register info in,
// forwarding selects and stall/bubble controls out.
interface hazard_ctrl_nport_if #(
  parameter int NUM_SRC = 2
);
  logic [5*NUM_SRC-1:0] src_reg_e;
  logic [NUM_SRC-1:0]   src_valid_e;
  logic [4:0]           write_reg_m;
  logic                 reg_write_m;
  logic                 mem_to_reg_m;
  logic [4:0]           write_reg_w;
  logic                 reg_write_w;
  logic [2*NUM_SRC-1:0] forward_sel;
  logic                 stall_cpu;
  logic                 bubble_m;

  modport master (
    output src_reg_e, src_valid_e, write_reg_m, reg_write_m, mem_to_reg_m,
           write_reg_w, reg_write_w,
    input  forward_sel, stall_cpu, bubble_m
  );

  modport slave (
    input  src_reg_e, src_valid_e, write_reg_m, reg_write_m, mem_to_reg_m,
           write_reg_w, reg_write_w,
    output forward_sel, stall_cpu, bubble_m
  );
endinterface

// File: rtl/hazard_ctrl_nport.sv
// N-operand hazard controller: M/W forwarding, LOAD_LAT-cycle load-use stall,
// external stall merge and a saturating stall-cycle counter.
module hazard_ctrl_nport #(
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_ctrl_nport_if.slave    hz,
  input  logic                  stall_req_i,
  input  logic                  fwd_en_i,
  input  logic                  clear_count_i,
  output logic [CNT_W-1:0]      stall_count_o
);

  typedef enum logic {IDLE, LU_STALL} state_t;

  // First cycle of a load-use stall is spent in IDLE, so the countdown covers the rest.
  localparam logic [3:0] LU_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

  state_t               state_q, state_d;
  logic [3:0]           lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]     stall_count_q, stall_count_d;
  logic [NUM_SRC-1:0]   match_m, match_w;
  logic                 load_use, any_match;
  logic                 fsm_stall, fsm_bubble;
  logic                 stall_cpu, bubble_m;
  logic [2*NUM_SRC-1:0] fwd_sel;

  always_comb begin
    match_m = '0;
    match_w = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      match_m[i] = hz.src_valid_e[i] & hz.reg_write_m &
                   (hz.src_reg_e[5*i +: 5] == hz.write_reg_m) &
                   (hz.src_reg_e[5*i +: 5] != 5'd0);
      match_w[i] = hz.src_valid_e[i] & hz.reg_write_w &
                   (hz.src_reg_e[5*i +: 5] == hz.write_reg_w) &
                   (hz.src_reg_e[5*i +: 5] != 5'd0);
    end
  end

  assign load_use  = (|match_m) & hz.mem_to_reg_m;
  assign any_match = (|match_m) | (|match_w);

  always_comb begin
    state_d    = state_q;
    lu_cnt_d   = lu_cnt_q;
    fsm_stall  = 1'b0;
    fsm_bubble = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_use) begin
          fsm_stall  = 1'b1;
          fsm_bubble = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d  = LU_STALL;
            lu_cnt_d = LU_INIT;
          end
        end else if (!fwd_en_i && any_match) begin
          // Stall-only mode: hold E until the producer has retired.
          fsm_stall  = 1'b1;
          fsm_bubble = 1'b1;
        end
      end
      LU_STALL: begin
        fsm_stall = 1'b1;
        if (lu_cnt_q == 4'd0) state_d = IDLE;
        else                  lu_cnt_d = lu_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_cpu = rst_n & (fsm_stall | stall_req_i);
  assign bubble_m  = rst_n & fsm_bubble;

  always_comb begin
    fwd_sel = '0;
    if (rst_n && fwd_en_i && !stall_cpu) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (match_m[i] && !hz.mem_to_reg_m) fwd_sel[2*i +: 2] = 2'b01;
        else if (match_w[i])                fwd_sel[2*i +: 2] = 2'b10;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (clear_count_i)
      stall_count_d = '0;
    else if (stall_cpu && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      lu_cnt_q      <= 4'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      lu_cnt_q      <= lu_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.forward_sel = fwd_sel;
  assign hz.stall_cpu   = stall_cpu;
  assign hz.bubble_m    = bubble_m;
  assign stall_count_o  = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl_nport.sv
// Bench for hazard_ctrl_nport: dut_a has LOAD_LAT=3/CNT_W=4, dut_b LOAD_LAT=1/CNT_W=16,
// both fed identical pipeline inputs.
module tb_hazard_ctrl_nport;

  typedef struct packed {
    logic [9:0] src;
    logic [1:0] vld;
    logic [4:0] wm;
    logic       rwm;
    logic       mtr;
    logic [4:0] ww;
    logic       rww;
    logic       sreq;
    logic       fwd;
  } stim_t;

  typedef struct packed {
    logic [3:0] fsel;
    logic       stall;
    logic       bub;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] src = '0;
  logic [1:0] vld = '0;
  logic [4:0] wm = '0, ww = '0;
  logic       rwm = 1'b0, mtr = 1'b0, rww = 1'b0;
  logic       sreq = 1'b0, fwd = 1'b1, clr = 1'b0;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  int checks = 0;
  int passes = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;

  hazard_ctrl_nport_if #(.NUM_SRC(2)) ifa ();
  hazard_ctrl_nport_if #(.NUM_SRC(2)) ifb ();

  assign ifa.src_reg_e = src;  assign ifb.src_reg_e = src;
  assign ifa.src_valid_e = vld; assign ifb.src_valid_e = vld;
  assign ifa.write_reg_m = wm; assign ifb.write_reg_m = wm;
  assign ifa.reg_write_m = rwm; assign ifb.reg_write_m = rwm;
  assign ifa.mem_to_reg_m = mtr; assign ifb.mem_to_reg_m = mtr;
  assign ifa.write_reg_w = ww; assign ifb.write_reg_w = ww;
  assign ifa.reg_write_w = rww; assign ifb.reg_write_w = rww;

  hazard_ctrl_nport #(.NUM_SRC(2), .LOAD_LAT(3), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .hz(ifa.slave), .stall_req_i(sreq),
    .fwd_en_i(fwd), .clear_count_i(clr), .stall_count_o(cnt_a)
  );

  hazard_ctrl_nport #(.NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .hz(ifb.slave), .stall_req_i(sreq),
    .fwd_en_i(fwd), .clear_count_i(clr), .stall_count_o(cnt_b)
  );

  function automatic stim_t mk(input logic [4:0] s1, input logic [4:0] s0,
                               input logic [1:0] v, input logic [4:0] m,
                               input logic rm, input logic ld, input logic [4:0] w,
                               input logic rw, input logic sr, input logic fe);
    stim_t s;
    s.src = {s1, s0}; s.vld = v; s.wm = m; s.rwm = rm; s.mtr = ld;
    s.ww = w; s.rww = rw; s.sreq = sr; s.fwd = fe;
    return s;
  endfunction

  function automatic exp_t ex(input logic [3:0] f, input logic s, input logic b);
    return {f, s, b};
  endfunction

  task automatic drive(input stim_t s);
    src = s.src; vld = s.vld; wm = s.wm; rwm = s.rwm; mtr = s.mtr;
    ww = s.ww; rww = s.rww; sreq = s.sreq; fwd = s.fwd;
  endtask

  function automatic stim_t idle();
    return mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  task automatic test_reset();
    exp_t ea, eb;
    #1 rst_n = 1'b0;
    drive(mk(0, 9, 2'b01, 9, 1, 1, 9, 1, 1, 1));
    repeat (2) @(posedge clk);
    sb_a.push_back(ex(4'b0000, 0, 0)); sb_b.push_back(ex(4'b0000, 0, 0));
    @(negedge clk);
    ea = sb_a.pop_front(); eb = sb_b.pop_front();
    checks++; if ({ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m} !== ea)
      $display("FAIL reset_out_a got %b want %b", {ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m}, ea); else passes++;
    checks++; if ({ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m} !== eb)
      $display("FAIL reset_out_b got %b want %b", {ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m}, eb); else passes++;
    checks++; if (cnt_a !== 4'd0) $display("FAIL reset_cnt_a got %0d want 0", cnt_a); else passes++;
    checks++; if (cnt_b !== 16'd0) $display("FAIL reset_cnt_b got %0d want 0", cnt_b); else passes++;
    @(posedge clk); #1 drive(idle()); rst_n = 1'b1;
  endtask

  task automatic test_forward();
    stim_t st[7]; exp_t e[7]; exp_t ea, eb;
    st[0] = mk(0, 7, 2'b01, 7, 1, 0, 7, 1, 0, 1); e[0] = ex(4'b0001, 0, 0);
    st[1] = mk(5, 7, 2'b11, 3, 1, 0, 5, 1, 0, 1); e[1] = ex(4'b1000, 0, 0);
    st[2] = mk(7, 7, 2'b10, 7, 1, 0, 7, 1, 0, 1); e[2] = ex(4'b0100, 0, 0);
    st[3] = mk(0, 6, 2'b01, 6, 0, 0, 6, 1, 0, 1); e[3] = ex(4'b0010, 0, 0);
    st[4] = mk(0, 0, 2'b10, 0, 1, 0, 0, 1, 0, 1); e[4] = ex(4'b0000, 0, 0);
    st[5] = mk(0, 0, 2'b11, 0, 1, 1, 0, 1, 0, 1); e[5] = ex(4'b0000, 0, 0);
    st[6] = mk(9, 2, 2'b01, 9, 1, 1, 0, 0, 0, 1); e[6] = ex(4'b0000, 0, 0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 drive(st[i]);
      sb_a.push_back(e[i]); sb_b.push_back(e[i]);
      @(negedge clk);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      checks++; if ({ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m} !== ea)
        $display("FAIL forward[%0d] a got %b want %b", i, {ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m}, ea); else passes++;
      checks++; if ({ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m} !== eb)
        $display("FAIL forward[%0d] b got %b want %b", i, {ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m}, eb); else passes++;
    end
    checks++; if (cnt_a !== 4'd0) $display("FAIL forward_cnt_a got %0d want 0", cnt_a); else passes++;
  endtask

  // Generic table runner body is repeated per scenario so each keeps its own checks.
  task automatic test_load_use();
    stim_t st[4]; exp_t xa[4], xb[4]; exp_t ea, eb;
    st[0] = mk(0, 9, 2'b01, 9, 1, 1, 0, 0, 0, 1); xa[0] = ex(0, 1, 1); xb[0] = ex(0, 1, 1);
    st[1] = mk(5, 9, 2'b11, 9, 1, 1, 5, 1, 0, 1); xa[1] = ex(0, 1, 0); xb[1] = ex(0, 1, 1);
    st[2] = mk(5, 9, 2'b11, 9, 1, 1, 5, 1, 0, 1); xa[2] = ex(0, 1, 0); xb[2] = ex(0, 1, 1);
    st[3] = idle();                               xa[3] = ex(0, 0, 0); xb[3] = ex(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 drive(st[i]);
      sb_a.push_back(xa[i]); sb_b.push_back(xb[i]);
      @(negedge clk);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      checks++; if ({ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m} !== ea)
        $display("FAIL load_use[%0d] a got %b want %b", i, {ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m}, ea); else passes++;
      checks++; if ({ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m} !== eb)
        $display("FAIL load_use[%0d] b got %b want %b", i, {ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m}, eb); else passes++;
    end
    checks++; if (cnt_a !== 4'd3) $display("FAIL load_use_cnt_a got %0d want 3", cnt_a); else passes++;
    checks++; if (cnt_b !== 16'd3) $display("FAIL load_use_cnt_b got %0d want 3", cnt_b); else passes++;
  endtask

  task automatic test_fwd_toggle();
    stim_t st[4]; exp_t xa[4], xb[4]; exp_t ea, eb;
    st[0] = mk(0, 9, 2'b01, 9, 1, 1, 0, 0, 0, 1); xa[0] = ex(0, 1, 1); xb[0] = ex(0, 1, 1);
    st[1] = mk(0, 3, 2'b01, 0, 0, 0, 3, 1, 0, 0); xa[1] = ex(0, 1, 0); xb[1] = ex(0, 1, 1);
    st[2] = idle();                               xa[2] = ex(0, 1, 0); xb[2] = ex(0, 0, 0);
    st[3] = idle();                               xa[3] = ex(0, 0, 0); xb[3] = ex(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 drive(st[i]);
      sb_a.push_back(xa[i]); sb_b.push_back(xb[i]);
      @(negedge clk);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      checks++; if ({ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m} !== ea)
        $display("FAIL fwd_toggle[%0d] a got %b want %b", i, {ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m}, ea); else passes++;
      checks++; if ({ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m} !== eb)
        $display("FAIL fwd_toggle[%0d] b got %b want %b", i, {ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m}, eb); else passes++;
    end
    checks++; if (cnt_a !== 4'd6) $display("FAIL fwd_toggle_cnt_a got %0d want 6", cnt_a); else passes++;
    checks++; if (cnt_b !== 16'd5) $display("FAIL fwd_toggle_cnt_b got %0d want 5", cnt_b); else passes++;
  endtask

  task automatic test_stall_only();
    stim_t st[5]; exp_t e[5]; exp_t ea, eb;
    st[0] = mk(4, 0, 2'b10, 0, 0, 0, 4, 1, 0, 0); e[0] = ex(4'b0000, 1, 1);
    st[1] = idle();                               e[1] = ex(4'b0000, 0, 0);
    st[2] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1); e[2] = ex(4'b0000, 1, 0);
    st[3] = mk(0, 7, 2'b01, 7, 1, 0, 0, 0, 1, 1); e[3] = ex(4'b0000, 1, 0);
    st[4] = mk(0, 7, 2'b01, 7, 1, 0, 0, 0, 0, 1); e[4] = ex(4'b0001, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 drive(st[i]);
      sb_a.push_back(e[i]); sb_b.push_back(e[i]);
      @(negedge clk);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      checks++; if ({ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m} !== ea)
        $display("FAIL stall_only[%0d] a got %b want %b", i, {ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m}, ea); else passes++;
      checks++; if ({ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m} !== eb)
        $display("FAIL stall_only[%0d] b got %b want %b", i, {ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m}, eb); else passes++;
    end
    checks++; if (cnt_a !== 4'd9) $display("FAIL stall_only_cnt_a got %0d want 9", cnt_a); else passes++;
    checks++; if (cnt_b !== 16'd8) $display("FAIL stall_only_cnt_b got %0d want 8", cnt_b); else passes++;
  endtask

  task automatic test_load_plus_req();
    stim_t st[4]; exp_t e[4]; exp_t ea, eb;
    st[0] = mk(0, 9, 2'b01, 9, 1, 1, 0, 0, 1, 1); e[0] = ex(0, 1, 1);
    st[1] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1); e[1] = ex(0, 1, 0);
    st[2] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1); e[2] = ex(0, 1, 0);
    st[3] = idle();                               e[3] = ex(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 drive(st[i]);
      sb_a.push_back(e[i]); sb_b.push_back(e[i]);
      @(negedge clk);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      checks++; if ({ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m} !== ea)
        $display("FAIL load_plus_req[%0d] a got %b want %b", i, {ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m}, ea); else passes++;
      checks++; if ({ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m} !== eb)
        $display("FAIL load_plus_req[%0d] b got %b want %b", i, {ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m}, eb); else passes++;
    end
    checks++; if (cnt_a !== 4'd12) $display("FAIL load_plus_req_cnt_a got %0d want 12", cnt_a); else passes++;
    checks++; if (cnt_b !== 16'd11) $display("FAIL load_plus_req_cnt_b got %0d want 11", cnt_b); else passes++;
  endtask

  task automatic test_saturate();
    exp_t ea;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 drive(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1));
      sb_a.push_back(ex(0, 1, 0));
      @(negedge clk);
      ea = sb_a.pop_front();
      checks++; if ({ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m} !== ea)
        $display("FAIL saturate[%0d] a got %b want %b", i, {ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m}, ea); else passes++;
    end
    @(posedge clk); #1 clr = 1'b1;
    @(negedge clk);
    checks++; if (cnt_a !== 4'd15) $display("FAIL saturate_cnt_a got %0d want 15", cnt_a); else passes++;
    checks++; if (cnt_b !== 16'd31) $display("FAIL saturate_cnt_b got %0d want 31", cnt_b); else passes++;
    @(posedge clk); #1 clr = 1'b0; drive(idle());
    @(negedge clk);
    checks++; if (cnt_a !== 4'd0) $display("FAIL clear_cnt_a got %0d want 0", cnt_a); else passes++;
    checks++; if (cnt_b !== 16'd0) $display("FAIL clear_cnt_b got %0d want 0", cnt_b); else passes++;
  endtask

  task automatic test_reset_mid();
    stim_t st[6]; exp_t xa[6], xb[6]; exp_t ea, eb;
    st[0] = mk(0, 9, 2'b01, 9, 1, 1, 0, 0, 0, 1); xa[0] = ex(0, 1, 1); xb[0] = ex(0, 1, 1);
    st[1] = idle();                               xa[1] = ex(0, 1, 0); xb[1] = ex(0, 0, 0);
    st[2] = mk(0, 9, 2'b01, 9, 1, 1, 0, 0, 0, 1); xa[2] = ex(0, 1, 1); xb[2] = ex(0, 1, 1);
    st[3] = idle();                               xa[3] = ex(0, 1, 0); xb[3] = ex(0, 0, 0);
    st[4] = idle();                               xa[4] = ex(0, 1, 0); xb[4] = ex(0, 0, 0);
    st[5] = idle();                               xa[5] = ex(0, 0, 0); xb[5] = ex(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        // Abort dut_a in its second LU_STALL cycle, then restart from IDLE.
        @(posedge clk); #1 drive(idle()); #1 rst_n = 1'b0; #1;
        sb_a.push_back(ex(0, 0, 0));
        ea = sb_a.pop_front();
        checks++; if ({ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m} !== ea)
          $display("FAIL reset_mid_out got %b want %b", {ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m}, ea); else passes++;
        checks++; if (cnt_a !== 4'd0) $display("FAIL reset_mid_cnt got %0d want 0", cnt_a); else passes++;
        @(posedge clk); #1 rst_n = 1'b1;
        sb_a.push_back(ex(0, 0, 0));
        @(negedge clk);
        ea = sb_a.pop_front();
        checks++; if ({ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m} !== ea)
          $display("FAIL reset_mid_release got %b want %b", {ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m}, ea); else passes++;
      end
      @(posedge clk); #1 drive(st[i]);
      sb_a.push_back(xa[i]); sb_b.push_back(xb[i]);
      @(negedge clk);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      checks++; if ({ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m} !== ea)
        $display("FAIL reset_mid[%0d] a got %b want %b", i, {ifa.forward_sel, ifa.stall_cpu, ifa.bubble_m}, ea); else passes++;
      checks++; if ({ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m} !== eb)
        $display("FAIL reset_mid[%0d] b got %b want %b", i, {ifb.forward_sel, ifb.stall_cpu, ifb.bubble_m}, eb); else passes++;
    end
    checks++; if (cnt_a !== 4'd3) $display("FAIL reset_mid_cnt_a got %0d want 3", cnt_a); else passes++;
    checks++; if (cnt_b !== 16'd1) $display("FAIL reset_mid_cnt_b got %0d want 1", cnt_b); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_fwd_toggle();
    test_stall_only();
    test_load_plus_req();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_nport.md
HAZARD_CTRL_NPORT -- requirements
Module: hazard_ctrl_nport

Interface
REQ-001 Parameter NUM_SRC, default 2, number of E-stage source operands checked.
REQ-002 Parameter LOAD_LAT, default 1, range 1..15, load-use stall length in cycles.
REQ-003 Parameter CNT_W, default 16, width of stall-cycle counter.
REQ-004 Clock  input  1  single clock; all state on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-006 SrcRegE  input  5*NUM_SRC  packed E-stage source register numbers, operand i at [5i+4:5i].
REQ-007 SrcValidE  input  NUM_SRC  operand i actually read by the E-stage instruction.
REQ-008 WriteRegM, RegWriteM, MemToRegM  input  5,1,1  M-stage destination, write enable, load flag.
REQ-009 WriteRegW, RegWriteW  input  5,1  W-stage destination, write enable.
REQ-010 StallReq  input  1  external level stall request (e.g. memory busy).
REQ-011 FwdEn  input  1  1 = forwarding mode, 0 = stall-only mode.
REQ-012 ClearCount  input  1  synchronous clear of StallCount.
REQ-013 ForwardSel  output  2*NUM_SRC  per operand: 00 regfile, 01 from M, 10 from W; 11 never driven.
REQ-014 StallCPU  output  1  freeze PC, F and E registers this cycle.
REQ-015 BubbleM  output  1  load a bubble into M this cycle.
REQ-016 StallCount  output  CNT_W  saturating count of cycles with StallCPU=1.

Function
REQ-017 Match(i,X) SHALL be SrcValidE[i] & RegWriteX & (SrcReg_i == WriteRegX) & (SrcReg_i != 0).
REQ-018 With FwdEn=1, ForwardSel_i SHALL be 01 on Match(i,M) & !MemToRegM, else 10 on Match(i,W), else 00; M has priority over W.
REQ-019 ForwardSel SHALL be combinational (zero latency) and SHALL be 00 for all operands while StallCPU=1 or FwdEn=0.
REQ-020 Load-use hazard SHALL be any Match(i,M) with MemToRegM=1, evaluated only in state IDLE.
REQ-021 FSM states SHALL be IDLE and LU_STALL, with a 4-bit down-counter LuCnt.
REQ-022 IDLE: load-use hazard SHALL assert StallCPU and BubbleM combinationally that cycle; if LOAD_LAT>1 go to LU_STALL with LuCnt=LOAD_LAT-2, else remain IDLE.
REQ-023 LU_STALL: StallCPU SHALL be 1, BubbleM 0, hazard detection suppressed; LuCnt==0 returns to IDLE, else LuCnt decrements.
REQ-024 Total load-use stall SHALL be exactly LOAD_LAT consecutive cycles.
REQ-025 StallReq=1 SHALL assert StallCPU in any state, same cycle, without asserting BubbleM.
REQ-026 StallReq during LU_STALL SHALL NOT pause LuCnt; StallCPU stays 1 while either source is active.
REQ-027 Load-use hazard and StallReq in the same IDLE cycle: StallCPU=1, BubbleM=1, FSM advances per REQ-022.
REQ-028 FwdEn=0: any Match(i,M) or Match(i,W) SHALL assert StallCPU combinationally, BubbleM=1, FSM untouched.
REQ-029 Changing FwdEn while in LU_STALL SHALL NOT abort the LU_STALL countdown.
REQ-030 StallCount SHALL increment by 1 on each edge where StallCPU=1, saturating at 2^CNT_W-1.
REQ-031 ClearCount=1 SHALL zero StallCount at the edge, overriding increment.
REQ-032 Register 0 SHALL never forward nor cause a stall.

Reset
REQ-033 Reset=0 SHALL asynchronously force state IDLE, LuCnt=0, StallCount=0.
REQ-034 While Reset=0, ForwardSel SHALL be all 0, StallCPU=0, BubbleM=0 regardless of inputs.
REQ-035 Reset asserted mid-LU_STALL SHALL abort the stall; after release, first edge evaluates from IDLE.

Verification
REQ-036 FwdEn=1, SrcReg0=7 valid, WriteRegM=7 RegWriteM=1 MemToRegM=0, WriteRegW=7 RegWriteW=1 -> ForwardSel[1:0]=01, StallCPU=0.
REQ-037 SrcReg1=0 valid matching WriteRegM=0 and WriteRegW=0, both enables 1 -> ForwardSel[3:2]=00, StallCPU=0, StallCount unchanged.
REQ-038 LOAD_LAT=3, SrcReg0=9 valid, WriteRegM=9 RegWriteM=1 MemToRegM=1 held -> StallCPU=1 for exactly 3 cycles, BubbleM=1 only in first, StallCount=3.
REQ-039 FwdEn=0, SrcReg1=4 valid, WriteRegW=4 RegWriteW=1 -> StallCPU=1, BubbleM=1, ForwardSel=0; StallReq alone -> StallCPU=1, BubbleM=0.
REQ-040 CNT_W=4, StallReq held 20 cycles -> StallCount saturates at 15; ClearCount pulse -> 0.
REQ-041 Reset=0 asserted in second cycle of LU_STALL (LOAD_LAT=3) -> StallCPU=0 immediately, StallCount=0; after release with no hazard, StallCPU=0.
